cache_line_req_sequencer: RTL and testbench
===========================================

// Module: cache_line_req_sequencer
// PURPOSE
//  Consumes one reference block (start pixel position plus line-crossing deltas from the
//  valid-cache-line counter) and issues one cache-line request per covered line.
//  Walks lines row-major, one per accepted handshake. Sits between reference-block
//  address generation and the cache tag-lookup stage.
// PARAMETERS
//  C_L_H_SIZE   3   log2 of cache-line width in pixels (8)
//  C_L_V_SIZE   2   log2 of cache-line height in rows (4)
//  X_WDTH       12  pixel x-coordinate width
//  Y_WDTH       12  pixel y-coordinate width
// PORTS
//  clk             in   1                  clock, rising edge
//  reset           in   1                  synchronous, active-high
//  blk_valid_in    in   1                  block descriptor valid
//  blk_ready_out   out  1                  sequencer can accept a descriptor
//  start_x_in      in   X_WDTH             block top-left x, pixels
//  start_y_in      in   Y_WDTH             block top-left y, pixels
//  delta_x_in      in   2                  extra line columns spanned (0..3)
//  delta_y_in      in   2                  extra line rows spanned (0..3)
//  req_valid_out   out  1                  line request valid
//  req_ready_in    in   1                  downstream accepts request
//  req_line_x_out  out  X_WDTH-C_L_H_SIZE  cache-line column index
//  req_line_y_out  out  Y_WDTH-C_L_V_SIZE  cache-line row index
//  req_idx_out     out  4                  request ordinal in block, 0-based
//  req_last_out    out  1                  final request of block
// BEHAVIOUR
//  - Reset: FSM=IDLE; req_valid_out=0, req_last_out=0, req_line_x/y_out=0, req_idx_out=0;
//    all counters 0. Reset mid-block discards the block; no further requests.
//  - States: IDLE, ISSUE.
//  - blk_ready_out = (state==IDLE) | (state==ISSUE & req_valid_out & req_ready_in & req_last_out).
//    Combinational from state and req_ready_in.
//  - Accept (blk_valid_in & blk_ready_out): latch base_x=start_x_in>>C_L_H_SIZE,
//    base_y=start_y_in>>C_L_V_SIZE, dx=delta_x_in, dy=delta_y_in. Clear col, row and idx.
//    Next cycle: state=ISSUE, req_valid_out=1. Latency accept->first request: 1 clk.
//  - Outputs are registered. req_line_x_out=base_x+col, req_line_y_out=base_y+row.
//    Sums are modulo 2^width; wrap-around at the frame edge is intended and is not flagged.
//  - req_last_out = (col==dx) & (row==dy).
//  - Request handshake: req_valid_out & req_ready_in. All req_* outputs hold stable while
//    req_ready_in=0.
//  - On a non-last handshake: if col==dx then col=0, row++; else col++. idx++.
//    Next request is presented the following clk, so throughput is 1 request/clk.
//  - On the last handshake:
//    - with blk_valid_in=1: new block accepted the same cycle; its first request is
//      presented the next clk, with no bubble.
//    - otherwise: state=IDLE, req_valid_out=0.
//  - Request count per block = (dx+1)*(dy+1), from 1 to 16. idx range is 0..15.
//  - blk_valid_in is ignored while blk_ready_out=0. The upstream holds the descriptor.
// CONFIGURATION
//  CL_REQ_COL_MAJOR_EN defined:
//   - order is column-major: row is the inner counter, col the outer.
//   - req_last_out is unchanged: (col==dx)&(row==dy).
//  Not defined: row-major order, as above.
// TESTING
//  1. start=(16,8), delta=(0,0) -> 1 request, line (2,2), idx 0, last=1; blk_ready high next clk.
//  2. start=(5,3), delta=(2,3), ready tied 1 -> 12 requests, lines (0,0),(1,0),(2,0),(0,1)..(2,3);
//     last on idx 11.
//  3. Case 2 with req_ready_in toggling 1/0 -> outputs stable during stalls; same 12-request sequence.
//  4. Back-to-back: second descriptor valid during first block's last handshake -> accepted
//     same cycle; next-clk request is the new block's idx 0.
//  5. start_x=0xFF8, delta_x=1 -> line_x 0x1FF then 0x000 (wrap); no error.
//  6. reset asserted after 3 of 12 requests -> req_valid_out=0 next clk, blk_ready_out=1;
//     a new block starts at idx 0.

Source files
------------

// File: rtl/cache_line_req_sequencer.sv
// Walks the cache lines covered by one reference block and issues one line request per handshake.
// Optional CL_REQ_COL_MAJOR_EN selects column-major walk order (default: row-major).
module cache_line_req_sequencer #(
  parameter int unsigned C_L_H_SIZE = 3,
  parameter int unsigned C_L_V_SIZE = 2,
  parameter int unsigned X_WDTH     = 12,
  parameter int unsigned Y_WDTH     = 12
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         blk_valid_in,
  output logic                         blk_ready_out,
  input  logic [X_WDTH-1:0]            start_x_in,
  input  logic [Y_WDTH-1:0]            start_y_in,
  input  logic [1:0]                   delta_x_in,
  input  logic [1:0]                   delta_y_in,
  output logic                         req_valid_out,
  input  logic                         req_ready_in,
  output logic [X_WDTH-C_L_H_SIZE-1:0] req_line_x_out,
  output logic [Y_WDTH-C_L_V_SIZE-1:0] req_line_y_out,
  output logic [3:0]                   req_idx_out,
  output logic                         req_last_out
);

  localparam int unsigned LineXW = X_WDTH - C_L_H_SIZE;
  localparam int unsigned LineYW = Y_WDTH - C_L_V_SIZE;

  typedef enum logic [0:0] {StIdle, StIssue} state_e;

  state_e            state_q;
  logic [LineXW-1:0] base_x_q;
  logic [LineYW-1:0] base_y_q;
  logic [1:0]        dx_q, dy_q;
  logic [1:0]        col_q, row_q;
  logic [1:0]        col_d, row_d;
  logic [LineXW-1:0] start_line_x;
  logic [LineYW-1:0] start_line_y;
  logic              req_hs;
  logic              blk_accept;

  assign start_line_x  = LineXW'(start_x_in >> C_L_H_SIZE);
  assign start_line_y  = LineYW'(start_y_in >> C_L_V_SIZE);
  assign req_hs        = req_valid_out & req_ready_in;
  assign blk_ready_out = (state_q == StIdle) | ((state_q == StIssue) & req_hs & req_last_out);
  assign blk_accept    = blk_valid_in & blk_ready_out;

  // Position of the next line; only consumed on a non-last handshake, so no overflow guard.
  always_comb begin
    col_d = col_q;
    row_d = row_q;
`ifdef CL_REQ_COL_MAJOR_EN
    if (row_q == dy_q) begin
      row_d = 2'd0;
      col_d = col_q + 2'd1;
    end else begin
      row_d = row_q + 2'd1;
    end
`else
    if (col_q == dx_q) begin
      col_d = 2'd0;
      row_d = row_q + 2'd1;
    end else begin
      col_d = col_q + 2'd1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= StIdle;
      base_x_q       <= '0;
      base_y_q       <= '0;
      dx_q           <= '0;
      dy_q           <= '0;
      col_q          <= '0;
      row_q          <= '0;
      req_valid_out  <= 1'b0;
      req_line_x_out <= '0;
      req_line_y_out <= '0;
      req_idx_out    <= '0;
      req_last_out   <= 1'b0;
    end else if (blk_accept) begin
      // Covers both the idle accept and the bubble-free accept on a last handshake.
      state_q        <= StIssue;
      base_x_q       <= start_line_x;
      base_y_q       <= start_line_y;
      dx_q           <= delta_x_in;
      dy_q           <= delta_y_in;
      col_q          <= 2'd0;
      row_q          <= 2'd0;
      req_valid_out  <= 1'b1;
      req_line_x_out <= start_line_x;
      req_line_y_out <= start_line_y;
      req_idx_out    <= 4'd0;
      req_last_out   <= (delta_x_in == 2'd0) && (delta_y_in == 2'd0);
    end else if (req_hs) begin
      if (req_last_out) begin
        state_q       <= StIdle;
        req_valid_out <= 1'b0;
        req_last_out  <= 1'b0;
      end else begin
        col_q          <= col_d;
        row_q          <= row_d;
        req_line_x_out <= base_x_q + LineXW'(col_d);
        req_line_y_out <= base_y_q + LineYW'(row_d);
        req_idx_out    <= req_idx_out + 4'd1;
        req_last_out   <= (col_d == dx_q) && (row_d == dy_q);
      end
    end
  end

endmodule

// File: tb/tb_cache_line_req_sequencer.sv
// Self-checking bench for cache_line_req_sequencer; reference model enumerates the covered
// lines of each block by ordinal and compares every presented request against it.
module tb_cache_line_req_sequencer;

  localparam int LineW = 8;
  localparam int LineH = 4;
  localparam int ModX  = 512;
  localparam int ModY  = 1024;

  typedef struct packed {
    logic [8:0] lx;
    logic [9:0] ly;
    logic [3:0] idx;
    logic       last;
  } req_t;

  logic        clk;
  logic        reset;
  logic        blk_valid_in;
  logic        blk_ready_out;
  logic [11:0] start_x_in;
  logic [11:0] start_y_in;
  logic [1:0]  delta_x_in;
  logic [1:0]  delta_y_in;
  logic        req_valid_out;
  logic        req_ready_in;
  logic [8:0]  req_line_x_out;
  logic [9:0]  req_line_y_out;
  logic [3:0]  req_idx_out;
  logic        req_last_out;

  req_t got;
  req_t exp_q[$];
  int   vectors    = 0;
  int   miscompares = 0;

  assign got = {req_line_x_out, req_line_y_out, req_idx_out, req_last_out};

  cache_line_req_sequencer dut (
    .clk            (clk),
    .reset          (reset),
    .blk_valid_in   (blk_valid_in),
    .blk_ready_out  (blk_ready_out),
    .start_x_in     (start_x_in),
    .start_y_in     (start_y_in),
    .delta_x_in     (delta_x_in),
    .delta_y_in     (delta_y_in),
    .req_valid_out  (req_valid_out),
    .req_ready_in   (req_ready_in),
    .req_line_x_out (req_line_x_out),
    .req_line_y_out (req_line_y_out),
    .req_idx_out    (req_idx_out),
    .req_last_out   (req_last_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Appends the requests of one block, enumerated by ordinal k.
  function automatic void model(input int sx, input int sy, input int dx, input int dy);
    int n = (dx + 1) * (dy + 1);
    for (int k = 0; k < n; k++) begin
      int   col;
      int   row;
      req_t r;
`ifdef CL_REQ_COL_MAJOR_EN
      row = k % (dy + 1);
      col = k / (dy + 1);
`else
      col = k % (dx + 1);
      row = k / (dx + 1);
`endif
      r.lx   = 9'(((sx / LineW) + col) % ModX);
      r.ly   = 10'(((sy / LineH) + row) % ModY);
      r.idx  = 4'(k);
      r.last = (k == n - 1);
      exp_q.push_back(r);
    end
  endfunction

  task automatic drive_desc(input int sx, input int sy, input int dx, input int dy);
    start_x_in   = 12'(sx);
    start_y_in   = 12'(sy);
    delta_x_in   = 2'(dx);
    delta_y_in   = 2'(dy);
    blk_valid_in = 1'b1;
  endtask

  task automatic test_reset();
    reset        = 1'b1;
    blk_valid_in = 1'b0;
    req_ready_in = 1'b0;
    drive_desc(0, 0, 0, 0);
    blk_valid_in = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    vectors++;
    if (req_valid_out !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_valid: got %b, expected 0", req_valid_out);
    end
    vectors++;
    if (got !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %h, expected 0", got);
    end
    vectors++;
    if (blk_ready_out !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_blk_ready: got %b, expected 1", blk_ready_out);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single();
    req_t e;
    exp_q.delete();
    model(16, 8, 0, 0);
    e = exp_q[0];
    drive_desc(16, 8, 0, 0);
    req_ready_in = 1'b1;
    @(negedge clk);
    blk_valid_in = 1'b0;
    #1;
    vectors++;
    if (req_valid_out !== 1'b1 || got !== e || e.lx != 9'd2 || e.ly != 10'd2) begin
      miscompares++;
      $display("FAIL single_req: got v=%b %h, expected v=1 %h", req_valid_out, got, e);
    end
    vectors++;
    if (blk_ready_out !== 1'b1) begin
      miscompares++;
      $display("FAIL single_blk_ready_on_last: got %b, expected 1", blk_ready_out);
    end
    @(negedge clk);
    #1;
    vectors++;
    if (req_valid_out !== 1'b0 || blk_ready_out !== 1'b1) begin
      miscompares++;
      $display("FAIL single_idle: got v=%b rdy=%b, expected v=0 rdy=1", req_valid_out,
               blk_ready_out);
    end
  endtask

  // stall=1 toggles req_ready_in; a stalled request must re-present unchanged.
  task automatic test_sequence(input bit stall);
    int cyc = 0;
    int lasts = 0;
    exp_q.delete();
    model(5, 3, 2, 3);
    drive_desc(5, 3, 2, 3);
    req_ready_in = 1'b0;
    @(negedge clk);
    blk_valid_in = 1'b0;
    while (exp_q.size() > 0 && cyc < 100) begin
      req_ready_in = stall ? (cyc % 2 == 1) : 1'b1;
      #1;
      vectors++;
      if (req_valid_out !== 1'b1 || got !== exp_q[0]) begin
        miscompares++;
        $display("FAIL seq_req(stall=%0d): got v=%b %h, expected v=1 %h", stall, req_valid_out,
                 got, exp_q[0]);
      end
      if (req_ready_in) begin
        if (req_last_out === 1'b1) lasts++;
        void'(exp_q.pop_front());
      end
      cyc++;
      @(negedge clk);
    end
    vectors++;
    if (exp_q.size() != 0 || lasts != 1) begin
      miscompares++;
      $display("FAIL seq_count(stall=%0d): got left=%0d lasts=%0d, expected 0 and 1", stall,
               exp_q.size(), lasts);
    end
    #1;
    vectors++;
    if (req_valid_out !== 1'b0) begin
      miscompares++;
      $display("FAIL seq_end_valid: got %b, expected 0", req_valid_out);
    end
  endtask

  task automatic test_back_to_back();
    int cyc = 0;
    exp_q.delete();
    model(0, 0, 1, 0);
    model(64, 32, 0, 1);
    drive_desc(0, 0, 1, 0);
    req_ready_in = 1'b1;
    @(negedge clk);
    drive_desc(64, 32, 0, 1);
    while (exp_q.size() > 0 && cyc < 20) begin
      #1;
      vectors++;
      if (req_valid_out !== 1'b1 || got !== exp_q[0]) begin
        miscompares++;
        $display("FAIL b2b_req: got v=%b %h, expected v=1 %h", req_valid_out, got, exp_q[0]);
      end
      vectors++;
      if (blk_ready_out !== exp_q[0].last) begin
        miscompares++;
        $display("FAIL b2b_blk_ready: got %b, expected %b", blk_ready_out, exp_q[0].last);
      end
      void'(exp_q.pop_front());
      cyc++;
      @(negedge clk);
      if (exp_q.size() <= 2) blk_valid_in = 1'b0;
    end
    #1;
    vectors++;
    if (req_valid_out !== 1'b0 || exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL b2b_end: got v=%b left=%0d, expected v=0 left=0", req_valid_out,
               exp_q.size());
    end
  endtask

  task automatic test_wrap();
    int cyc = 0;
    exp_q.delete();
    model(12'hFF8, 0, 1, 0);
    drive_desc(12'hFF8, 0, 1, 0);
    req_ready_in = 1'b1;
    @(negedge clk);
    blk_valid_in = 1'b0;
    while (exp_q.size() > 0 && cyc < 10) begin
      #1;
      vectors++;
      if (req_valid_out !== 1'b1 || got !== exp_q[0]) begin
        miscompares++;
        $display("FAIL wrap_req: got v=%b %h, expected v=1 %h", req_valid_out, got, exp_q[0]);
      end
      void'(exp_q.pop_front());
      cyc++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid();
    exp_q.delete();
    model(5, 3, 2, 3);
    drive_desc(5, 3, 2, 3);
    req_ready_in = 1'b1;
    @(negedge clk);
    blk_valid_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      vectors++;
      if (req_valid_out !== 1'b1 || got !== exp_q[0]) begin
        miscompares++;
        $display("FAIL rmid_req: got v=%b %h, expected v=1 %h", req_valid_out, got, exp_q[0]);
      end
      void'(exp_q.pop_front());
      @(negedge clk);
    end
    reset        = 1'b1;
    req_ready_in = 1'b0;
    @(negedge clk);
    #1;
    vectors++;
    if (req_valid_out !== 1'b0 || blk_ready_out !== 1'b1) begin
      miscompares++;
      $display("FAIL rmid_after_reset: got v=%b rdy=%b, expected v=0 rdy=1", req_valid_out,
               blk_ready_out);
    end
    reset = 1'b0;
    exp_q.delete();
    model(8, 4, 0, 0);
    drive_desc(8, 4, 0, 0);
    @(negedge clk);
    blk_valid_in = 1'b0;
    #1;
    vectors++;
    if (req_valid_out !== 1'b1 || got !== exp_q[0]) begin
      miscompares++;
      $display("FAIL rmid_new_block: got v=%b %h, expected v=1 %h", req_valid_out, got, exp_q[0]);
    end
    req_ready_in = 1'b1;
    @(negedge clk);
    exp_q.delete();
  endtask

  task automatic test_random();
    int left    = 40;
    int cyc     = 0;
    bit holding = 1'b0;
    bit exp_rdy;
    int sx, sy, dx, dy;
    exp_q.delete();
    blk_valid_in = 1'b0;
    while ((left > 0 || holding || exp_q.size() > 0) && cyc < 3000) begin
      if (!holding && left > 0 && $urandom_range(0, 2) != 0) begin
        sx = int'($urandom_range(0, 4095));
        sy = int'($urandom_range(0, 4095));
        dx = int'($urandom_range(0, 3));
        dy = int'($urandom_range(0, 3));
        drive_desc(sx, sy, dx, dy);
        holding = 1'b1;
        left--;
      end
      blk_valid_in = holding;
      req_ready_in = ($urandom_range(0, 3) != 0);
      #1;
      exp_rdy = (exp_q.size() == 0) || (req_ready_in && exp_q[0].last);
      vectors++;
      if (blk_ready_out !== exp_rdy) begin
        miscompares++;
        $display("FAIL rand_blk_ready: got %b, expected %b", blk_ready_out, exp_rdy);
      end
      vectors++;
      if (exp_q.size() > 0) begin
        if (req_valid_out !== 1'b1 || got !== exp_q[0]) begin
          miscompares++;
          $display("FAIL rand_req: got v=%b %h, expected v=1 %h", req_valid_out, got,
                   exp_q[0]);
        end
      end else if (req_valid_out !== 1'b0) begin
        miscompares++;
        $display("FAIL rand_idle_valid: got %b, expected 0", req_valid_out);
      end
      if (exp_q.size() > 0 && req_ready_in) void'(exp_q.pop_front());
      if (holding && exp_rdy) begin
        model(sx, sy, dx, dy);
        holding = 1'b0;
      end
      cyc++;
      @(negedge clk);
    end
    if (cyc >= 3000) begin
      vectors++;
      miscompares++;
      $display("FAIL rand_timeout: got %0d requests pending, expected 0", exp_q.size());
    end
    blk_valid_in = 1'b0;
    req_ready_in = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_sequence(1'b0);
    test_sequence(1'b1);
    test_back_to_back();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
